// File: rtl/adt7410_poller_if.sv
// adt7410_poller_if: request/response handshake between the poller and the I2C controller wrapper
interface adt7410_poller_if;
    logic       start;
    logic       rd_wr;
    logic [7:0] address;
    logic [6:0] bus_address;
    logic [7:0] data_to_send;
    logic [7:0] data_received;
    logic       busy;
    logic       done;
    logic       error;
    modport master (output start, rd_wr, address, bus_address, data_to_send,
                    input data_received, busy, done, error);
    modport slave (input start, rd_wr, address, bus_address, data_to_send,
                   output data_received, busy, done, error);
endinterface

// File: rtl/adt7410_poller.sv
// adt7410_poller: writes the ADT7410 config once, then periodically reads MSB/LSB and publishes a 16-bit sample
module adt7410_poller #(
    parameter logic [6:0]  BUS_ADDRESS    = 7'h4B,
    parameter logic [7:0]  CONFIG_VALUE   = 8'h80,
    parameter int unsigned POLL_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    adt7410_poller_if.master        i2c,
    output logic [15:0]             temperature,
    output logic                    temp_valid,
    output logic [7:0]              error_count,
    output logic                    fault
);
    typedef enum logic [3:0] {
        IDLE, CFG_START, CFG_WAIT, PERIOD, MSB_START, MSB_WAIT, LSB_START, LSB_WAIT, PUBLISH, BACKOFF
    } state_t;
    state_t      state_q, state_d;
    logic        cfg_done_q, cfg_done_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        rd_wr_q, rd_wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] temp_q, temp_d;
    logic        valid_q, valid_d;
    logic [7:0]  err_q, err_d;
    logic        fault_q, fault_d;
    logic        waiting, launch, ok, fail, poll_end, lsb_ok;
    always_comb begin
        waiting  = state_q inside {CFG_WAIT, MSB_WAIT, LSB_WAIT};
        launch   = (state_q inside {CFG_START, MSB_START, LSB_START}) && !i2c.busy;
        ok       = waiting && i2c.done && !i2c.error;
        // done in the timeout cycle still counts as success
        fail     = waiting && (i2c.error || (!i2c.done && cnt_q == TIMEOUT_CYCLES));
        poll_end = cnt_q == POLL_CYCLES - 1;
        lsb_ok   = ok && state_q == LSB_WAIT;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable) state_d = cfg_done_q ? PERIOD : CFG_START;
            CFG_START: if (launch) state_d = CFG_WAIT;
            MSB_START: if (launch) state_d = MSB_WAIT;
            LSB_START: if (launch) state_d = LSB_WAIT;
            CFG_WAIT:  state_d = fail ? BACKOFF : ok ? PERIOD : state_q;
            MSB_WAIT:  state_d = fail ? BACKOFF : ok ? LSB_START : state_q;
            LSB_WAIT:  state_d = fail ? BACKOFF : ok ? PUBLISH : state_q;
            PUBLISH:   state_d = PERIOD;
            PERIOD, BACKOFF: begin
                if (!enable) state_d = IDLE;
                else if (poll_end) state_d = cfg_done_q ? MSB_START : CFG_START;
            end
            default:   state_d = IDLE;
        endcase
        // one counter serves both the poll interval and the transaction timeout
        cnt_d      = (state_d != state_q) ? '0 : cnt_q + 32'd1;
        cfg_done_d = cfg_done_q | (ok && state_q == CFG_WAIT);
        start_d    = launch;
        rd_wr_d    = launch ? state_q != CFG_START : rd_wr_q;
        addr_d     = !launch ? addr_q : state_q == CFG_START ? 8'h03 : state_q == MSB_START ? 8'h00 : 8'h01;
        data_d     = (launch && state_q == CFG_START) ? CONFIG_VALUE : data_q;
        msb_d      = (ok && state_q == MSB_WAIT) ? i2c.data_received : fail ? 8'h00 : msb_q;
        temp_d     = lsb_ok ? {msb_q, i2c.data_received} : temp_q;
        valid_d    = lsb_ok;
        err_d      = (fail && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        fault_d    = fail | (fault_q & !lsb_ok);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_done_q <= 1'b0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            rd_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            msb_q      <= '0;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            rd_wr_q    <= rd_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            msb_q      <= msb_d;
            temp_q     <= temp_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            fault_q    <= fault_d;
        end
    end
    assign i2c.start        = start_q;
    assign i2c.rd_wr        = rd_wr_q;
    assign i2c.address      = addr_q;
    assign i2c.bus_address  = BUS_ADDRESS;
    assign i2c.data_to_send = data_q;
    assign temperature      = temp_q;
    assign temp_valid       = valid_q;
    assign error_count      = err_q;
    assign fault            = fault_q;
endmodule
